// File: rtl/dpd_pkg.sv
// Shared types for the triple-buffered weight bank controller:
// bank indices, controller states and reset pointer values.
package dpd_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PEND,
        ST_SWAP
    } wbank_state_t;

    localparam bank_idx_t RST_ACTIVE = 2'd0;
    localparam bank_idx_t RST_SHADOW = 2'd1;
    localparam bank_idx_t RST_PREV   = 2'd2;

endpackage

// File: rtl/wbank_checksum.sv
// Running modulo-2**DATA_WIDTH sum of bank writes, compared against
// the host checksum captured with the commit request.
module wbank_checksum
    import dpd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fresh,
    input  logic                  add_en,
    input  logic [DATA_WIDTH-1:0] add_data,
    input  logic                  cap_en,
    input  logic [DATA_WIDTH-1:0] cap_sum,
    output logic                  match
);

    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] ref_q;
    logic [DATA_WIDTH-1:0] base;

    // First write of a load restarts the sum.
    assign base  = fresh ? '0 : sum_q;
    assign match = (sum_q == ref_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            ref_q <= '0;
        end else begin
            if (add_en) begin
                sum_q <= base + add_data;
            end
            if (cap_en) begin
                ref_q <= cap_sum;
            end
        end
    end

endmodule

// File: rtl/weight_bank_ctrl.sv
// Triple-buffered TDNN weight bank controller with host load, commit and rollback.
// Define WBANK_CHECKSUM_EN to add the commit_sum / commit_err checksum check.
module weight_bank_ctrl
    import dpd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BANK_DEPTH = 1298,
    parameter int BANK_AW    = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           tdnn_weight_addr,
    input  logic                  tdnn_busy,
    output logic [DATA_WIDTH-1:0] tdnn_weight_data,
    output logic [1:0]            weight_bank_sel,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [15:0]           upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_data,
    input  logic                  commit_req,
    input  logic                  rollback_req,
    output logic                  commit_done,
    output logic                  addr_err,
    output logic [BANK_AW+1:0]    mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef WBANK_CHECKSUM_EN
    ,
    input  logic [DATA_WIDTH-1:0] commit_sum,
    output logic                  commit_err
`endif
);

    wbank_state_t state_q;
    wbank_state_t state_d;
    bank_idx_t    active_q;
    bank_idx_t    shadow_q;
    bank_idx_t    prev_q;
    logic         addr_err_q;

    logic in_range;
    logic upd_fire;
    logic wr_fire;
    logic swap_fire;
    logic swap_ok;
    logic rb_fire;
    logic sum_ok;
    logic unused_hi;

    assign unused_hi = ^tdnn_weight_addr[15:BANK_AW];

    assign in_range  = {16'd0, upd_addr} < 32'(BANK_DEPTH);
    assign upd_ready = rst_n && !tdnn_busy &&
                       (state_q == ST_IDLE || state_q == ST_LOAD);
    assign upd_fire  = upd_valid && upd_ready;
    assign wr_fire   = upd_fire && in_range;

    // Swapping waits out busy so the active bank never moves mid-inference.
    assign swap_fire = rst_n && (state_q == ST_SWAP) && !tdnn_busy;
    assign swap_ok   = swap_fire && sum_ok;
    assign rb_fire   = rst_n && (state_q == ST_IDLE) && !tdnn_busy &&
                       rollback_req && !commit_req;

    assign commit_done      = swap_ok || rb_fire;
    assign addr_err         = addr_err_q;
    assign weight_bank_sel  = active_q;
    assign tdnn_weight_data = mem_rdata;

    // Writes only happen while not busy, so TDNN reads always own the port.
    always_comb begin
        mem_we    = wr_fire;
        mem_wdata = upd_data;
        if (wr_fire) begin
            mem_addr = {shadow_q, upd_addr[BANK_AW-1:0]};
        end else begin
            mem_addr = {active_q, tdnn_weight_addr[BANK_AW-1:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (wr_fire)     state_d = ST_LOAD;
            ST_LOAD: if (commit_req)  state_d = ST_PEND;
            ST_PEND: if (!tdnn_busy)  state_d = ST_SWAP;
            ST_SWAP: if (!tdnn_busy)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            active_q   <= RST_ACTIVE;
            shadow_q   <= RST_SHADOW;
            prev_q     <= RST_PREV;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (upd_fire && !in_range) begin
                addr_err_q <= 1'b1;
            end
            if (swap_ok) begin
                prev_q   <= active_q;
                active_q <= shadow_q;
                shadow_q <= prev_q;
            end else if (rb_fire) begin
                active_q <= prev_q;
                prev_q   <= active_q;
            end
        end
    end

`ifdef WBANK_CHECKSUM_EN
    logic load_cmt;
    logic sum_match;

    assign load_cmt = rst_n && (state_q == ST_LOAD) && commit_req;

    wbank_checksum #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .fresh    (state_q == ST_IDLE),
        .add_en   (wr_fire),
        .add_data (upd_data),
        .cap_en   (load_cmt),
        .cap_sum  (commit_sum),
        .match    (sum_match)
    );

    assign sum_ok     = sum_match;
    assign commit_err = swap_fire && !sum_match;
`else
    assign sum_ok = 1'b1;
`endif

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Scoreboard bench for weight_bank_ctrl: directed and random host/TDNN
// traffic checked against a bank-level model. Honours WBANK_CHECKSUM_EN.
module tb_weight_bank_ctrl;

    localparam int DW     = 16;
    localparam int DEPTH  = 1298;
    localparam int AW     = 11;
    localparam int STRIDE = 1 << AW;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PEND = 2;
    localparam int PH_SWAP = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   tdnn_weight_addr;
    logic          tdnn_busy;
    logic [DW-1:0] tdnn_weight_data;
    logic [1:0]    weight_bank_sel;
    logic          upd_valid;
    logic          upd_ready;
    logic [15:0]   upd_addr;
    logic [DW-1:0] upd_data;
    logic          commit_req;
    logic          rollback_req;
    logic          commit_done;
    logic          addr_err;
    logic [AW+1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef WBANK_CHECKSUM_EN
    logic [DW-1:0] commit_sum;
    logic          commit_err;
`endif

    always #5 clk = ~clk;

    weight_bank_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tdnn_weight_addr (tdnn_weight_addr),
        .tdnn_busy        (tdnn_busy),
        .tdnn_weight_data (tdnn_weight_data),
        .weight_bank_sel  (weight_bank_sel),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_addr         (upd_addr),
        .upd_data         (upd_data),
        .commit_req       (commit_req),
        .rollback_req     (rollback_req),
        .commit_done      (commit_done),
        .addr_err         (addr_err),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
`ifdef WBANK_CHECKSUM_EN
        ,
        .commit_sum       (commit_sum),
        .commit_err       (commit_err)
`endif
    );

    // Synchronous-read weight RAM, four bank slots of STRIDE words
    logic [DW-1:0] ram [0:4*STRIDE-1];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int idx;
        bit ready;
        bit we;
        bit done;
        bit cerr;
        int sel;
        bit err;
        int waddr;
    } exp_t;

    typedef struct {
        int idx;
        int data;
    } rd_t;

    exp_t exp_q[$];
    rd_t  rd_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    bit   mon_en = 1'b0;

    // Reference model: logical bank contents plus the pointer permutation
    logic [DW-1:0] m_bank [3][STRIDE];
    int            m_act = 0;
    int            m_shd = 1;
    int            m_prv = 2;
    int            m_ph  = PH_IDLE;
    bit            m_err = 1'b0;
    logic [DW-1:0] m_sum = '0;
    logic [DW-1:0] m_cap = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic eval();
        exp_t e;
        rd_t  r;
        bit   fire, inr, swap, good, rb;
        int   t;
        e.idx   = n_push;
        e.ready = rst_n && !tdnn_busy && (m_ph == PH_IDLE || m_ph == PH_LOAD);
        fire    = e.ready && upd_valid;
        inr     = int'(upd_addr) < DEPTH;
        e.we    = fire && inr;
        e.waddr = m_shd * STRIDE + int'(upd_addr[AW-1:0]);
        swap    = rst_n && m_ph == PH_SWAP && !tdnn_busy;
`ifdef WBANK_CHECKSUM_EN
        good    = (m_sum == m_cap);
`else
        good    = 1'b1;
`endif
        rb      = rst_n && m_ph == PH_IDLE && !tdnn_busy && rollback_req && !commit_req;
        e.done  = (swap && good) || rb;
        e.cerr  = swap && !good;
        e.sel   = m_act;
        e.err   = m_err;
        exp_q.push_back(e);
        if (tdnn_busy) begin
            r.idx  = n_push + 1;
            r.data = int'(m_bank[m_act][tdnn_weight_addr[AW-1:0]]);
            rd_q.push_back(r);
        end
        n_push++;
        if (!rst_n) begin
            m_act = 0;
            m_shd = 1;
            m_prv = 2;
            m_ph  = PH_IDLE;
            m_err = 1'b0;
        end else begin
            if (fire && !inr) m_err = 1'b1;
            if (e.we) begin
                m_bank[m_shd][upd_addr[AW-1:0]] = upd_data;
                m_sum = (m_ph == PH_IDLE) ? upd_data : m_sum + upd_data;
            end
            case (m_ph)
                PH_IDLE: begin
                    if (rb) begin
                        t = m_act; m_act = m_prv; m_prv = t;
                    end
                    if (e.we) m_ph = PH_LOAD;
                end
                PH_LOAD: if (commit_req) begin
`ifdef WBANK_CHECKSUM_EN
                    m_cap = commit_sum;
`endif
                    m_ph = PH_PEND;
                end
                PH_PEND: if (!tdnn_busy) m_ph = PH_SWAP;
                default: if (!tdnn_busy) begin
                    if (good) begin
                        t = m_prv; m_prv = m_act; m_act = m_shd; m_shd = t;
                    end
                    m_ph = PH_IDLE;
                end
            endcase
        end
    endtask

    // Monitor: pops one expectation per cycle and checks the DUT outputs
    always @(negedge clk) begin
        exp_t e;
        rd_t  r;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("upd_ready", 32'(upd_ready), 32'(e.ready));
            chk("mem_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("mem_addr", 32'(mem_addr), e.waddr);
            chk("commit_done", 32'(commit_done), 32'(e.done));
            chk("weight_bank_sel", 32'(weight_bank_sel), e.sel);
            chk("addr_err", 32'(addr_err), 32'(e.err));
`ifdef WBANK_CHECKSUM_EN
            chk("commit_err", 32'(commit_err), 32'(e.cerr));
`endif
            if (rd_q.size() != 0 && rd_q[0].idx == e.idx) begin
                r = rd_q.pop_front();
                chk("tdnn_weight_data", 32'(tdnn_weight_data), r.data);
            end
        end else if (mon_en) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry (t=%0t)", $time);
        end
    end

    task automatic cyc1();
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        tdnn_busy    = 1'b0;
        upd_valid    = 1'b0;
        commit_req   = 1'b0;
        rollback_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        upd_valid = 1'b1;
        upd_addr  = 16'(a);
        upd_data  = d;
        cyc1();
        upd_valid = 1'b0;
    endtask

    task automatic commit_and_wait(input int n);
`ifdef WBANK_CHECKSUM_EN
        commit_sum = m_sum;
`endif
        commit_req = 1'b1;
        cyc1();
        commit_req = 1'b0;
        repeat (n) cyc1();
    endtask

    task automatic rd(input int a);
        tdnn_busy        = 1'b1;
        tdnn_weight_addr = 16'(a);
        cyc1();
        tdnn_busy = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < STRIDE; a++) begin
                v = 16'($urandom);
                ram[b*STRIDE + a] = v;
                m_bank[b][a]      = v;
            end
        end
        for (int a = 3 * STRIDE; a < 4 * STRIDE; a++) ram[a] = '0;
        ram[5]       = 16'h1000;
        m_bank[0][5] = 16'h1000;

        rst_n            = 1'b0;
        tdnn_weight_addr = '0;
        upd_addr         = '0;
        upd_data         = '0;
`ifdef WBANK_CHECKSUM_EN
        commit_sum       = '0;
`endif
        idle_in();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) cyc1();
        rst_n = 1'b1;
        cyc1();

        // Read path from bank 0
        rd(5);
        cyc1();

        // Full bank load then commit; read back from the new active bank
        for (int a = 0; a < DEPTH; a++) wr(a, 16'h2000);
        commit_and_wait(4);
        rd(0);
        rd(DEPTH - 1);
        cyc1();

        // Rollback to the previous bank
        rollback_req = 1'b1;
        cyc1();
        rollback_req = 1'b0;
        rd(0);
        cyc1();

        // Commit during a long inference, with commit+rollback while pending
        for (int i = 0; i < 4; i++) wr(i * 3, 16'(16'h0100 + i));
        tdnn_busy = 1'b1;
`ifdef WBANK_CHECKSUM_EN
        commit_sum = m_sum;
`endif
        commit_req = 1'b1;
        cyc1();
        commit_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tdnn_weight_addr = 16'($urandom_range(0, DEPTH - 1));
            upd_valid        = (i % 3 == 0);
            commit_req       = (i == 50);
            rollback_req     = (i == 50);
            cyc1();
        end
        idle_in();
        repeat (3) cyc1();
        rd(3);
        cyc1();

        // Out-of-range write is dropped and addr_err sticks
        wr(7, 16'h0abc);
        wr(DEPTH, 16'hdead);
        wr(DEPTH - 1, 16'h0def);
        commit_and_wait(3);
        rd(DEPTH - 1);
        repeat (2) cyc1();

        // Commit in IDLE does nothing
        commit_req = 1'b1;
        cyc1();
        commit_req = 1'b0;
        repeat (2) cyc1();

        // Reset during LOAD abandons the load and clears addr_err
        wr(20, 16'h1111);
        wr(21, 16'h2222);
        rst_n = 1'b0;
        repeat (2) cyc1();
        rst_n = 1'b1;
        cyc1();
        rd(20);
        cyc1();

`ifdef WBANK_CHECKSUM_EN
        // Checksum mismatch leaves the active bank alone, a match swaps
        for (int i = 0; i < 4; i++) wr(10 + i, 16'h0001);
        commit_sum = 16'h0005;
        commit_req = 1'b1;
        cyc1();
        commit_req = 1'b0;
        repeat (3) cyc1();
        for (int i = 0; i < 4; i++) wr(10 + i, 16'h0001);
        commit_sum = 16'h0004;
        commit_req = 1'b1;
        cyc1();
        commit_req = 1'b0;
        repeat (3) cyc1();
        rd(10);
        cyc1();
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) tdnn_busy = !tdnn_busy;
            tdnn_weight_addr = 16'($urandom);
            upd_valid        = 1'($urandom_range(0, 1));
            upd_addr         = ($urandom_range(0, 49) == 0) ? 16'($urandom)
                                                            : 16'($urandom_range(0, DEPTH - 1));
            upd_data         = 16'($urandom);
            commit_req       = ($urandom_range(0, 29) == 0);
            rollback_req     = ($urandom_range(0, 29) == 0);
            rst_n            = ($urandom_range(0, 999) != 0);
`ifdef WBANK_CHECKSUM_EN
            commit_sum       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_sum;
`endif
            cyc1();
        end
        rst_n = 1'b1;
        idle_in();
        repeat (6) cyc1();

        mon_en = 1'b0;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
